// File: rtl/hazard_unit_pkg.sv
// Shared types, encodings and helpers for the MIPS hazard unit.
// No logic of its own; imported by the interface, comparator and top.
package hazard_unit_pkg;

  localparam int REG_AW = 5;
  localparam int TW     = 2;

  typedef logic [REG_AW-1:0] reg_t;
  typedef logic [TW-1:0]     tw_t;

  localparam tw_t T_USE_NONE = 2'b11;
  localparam tw_t T_NEW_JAL  = 2'd1;
  localparam tw_t T_NEW_ALU  = 2'd2;
  localparam tw_t T_NEW_LOAD = 2'd3;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_e;

  typedef struct packed {
    reg_t rs;
    reg_t rt;
    reg_t dst;
    logic we;
    tw_t  tnew;
  } e_stage_t;

  typedef struct packed {
    reg_t rt;
    reg_t dst;
    logic we;
    tw_t  tnew;
  } m_stage_t;

  typedef struct packed {
    reg_t dst;
    logic we;
  } w_stage_t;

  function automatic tw_t sat_dec(input tw_t t);
    return (t == '0) ? '0 : t - tw_t'(1);
  endfunction

  // A stage that does not write a GPR (or writes $0) records dst 0 so it never matches.
  function automatic reg_t keep_dst(input logic we, input reg_t dst);
    return we ? dst : '0;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// D-stage hazard annotations in, stall and forwarding selects out.
// Pure wiring; the pipeline (master) holds D whenever stall is high.
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  reg_t rs_d;
  reg_t rt_d;
  tw_t  t_use_rs_d;
  tw_t  t_use_rt_d;
  tw_t  t_new_d;
  logic reg_write_d;
  reg_t dst_d;

  logic stall;
  fwd_e fwd_rs_d;
  fwd_e fwd_rt_d;
  fwd_e fwd_rs_e;
  fwd_e fwd_rt_e;
  fwd_e fwd_rt_m;

  modport master (
    output rs_d, rt_d, t_use_rs_d, t_use_rt_d, t_new_d, reg_write_d, dst_d,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
  );

  modport slave (
    input  rs_d, rt_d, t_use_rs_d, t_use_rt_d, t_new_d, reg_write_d, dst_d,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
  );

endinterface

// File: rtl/hazard_unit_cmp.sv
// Matches one D-stage source (reg, t_use) against one in-flight stage (dst, we, tnew).
// Combinational, zero latency; no handshake.
module hazard_cmp
  import hazard_unit_pkg::*;
(
  input  reg_t src,
  input  tw_t  t_use,
  input  reg_t dst,
  input  logic we,
  input  tw_t  tnew,
  output logic stall_hit,
  output logic fwd_ok
);

  logic match;

  assign match     = (src != '0) && we && (src == dst);
  assign stall_hit = match && (t_use != T_USE_NONE) && (tnew > t_use);
  assign fwd_ok    = match && (tnew == '0);

endmodule

// File: rtl/hazard_unit.sv
// Tracks in-flight dst/T_new through E, M, W; drives stall and forwarding selects.
// Stall/forward are combinational from D inputs and state; stall holds D and bubbles E.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  hazard_unit_if.slave  hz
);

  e_stage_t e_q;
  m_stage_t m_q;
  w_stage_t w_q;

  logic rs_e_stall, rs_e_fwd, rs_m_stall, rs_m_fwd;
  logic rt_e_stall, rt_e_fwd, rt_m_stall, rt_m_fwd;
  logic rs_w_fwd, rt_w_fwd;

  hazard_cmp u_rs_e (.src(hz.rs_d), .t_use(hz.t_use_rs_d), .dst(e_q.dst), .we(e_q.we),
                     .tnew(e_q.tnew), .stall_hit(rs_e_stall), .fwd_ok(rs_e_fwd));
  hazard_cmp u_rs_m (.src(hz.rs_d), .t_use(hz.t_use_rs_d), .dst(m_q.dst), .we(m_q.we),
                     .tnew(m_q.tnew), .stall_hit(rs_m_stall), .fwd_ok(rs_m_fwd));
  hazard_cmp u_rt_e (.src(hz.rt_d), .t_use(hz.t_use_rt_d), .dst(e_q.dst), .we(e_q.we),
                     .tnew(e_q.tnew), .stall_hit(rt_e_stall), .fwd_ok(rt_e_fwd));
  hazard_cmp u_rt_m (.src(hz.rt_d), .t_use(hz.t_use_rt_d), .dst(m_q.dst), .we(m_q.we),
                     .tnew(m_q.tnew), .stall_hit(rt_m_stall), .fwd_ok(rt_m_fwd));

  // W results are always ready, and the regfile does not bypass, so W->D is required.
  assign rs_w_fwd = (hz.rs_d != '0) && w_q.we && (hz.rs_d == w_q.dst);
  assign rt_w_fwd = (hz.rt_d != '0) && w_q.we && (hz.rt_d == w_q.dst);

  assign hz.stall = rs_e_stall | rs_m_stall | rt_e_stall | rt_m_stall;

  always_comb begin
    hz.fwd_rs_d = rs_e_fwd ? FWD_E : rs_m_fwd ? FWD_M : rs_w_fwd ? FWD_W : FWD_RF;
    hz.fwd_rt_d = rt_e_fwd ? FWD_E : rt_m_fwd ? FWD_M : rt_w_fwd ? FWD_W : FWD_RF;

    hz.fwd_rs_e = FWD_RF;
    if (e_q.rs != '0 && m_q.we && e_q.rs == m_q.dst && m_q.tnew == '0)
      hz.fwd_rs_e = FWD_M;
    else if (e_q.rs != '0 && w_q.we && e_q.rs == w_q.dst)
      hz.fwd_rs_e = FWD_W;

    hz.fwd_rt_e = FWD_RF;
    if (e_q.rt != '0 && m_q.we && e_q.rt == m_q.dst && m_q.tnew == '0)
      hz.fwd_rt_e = FWD_M;
    else if (e_q.rt != '0 && w_q.we && e_q.rt == w_q.dst)
      hz.fwd_rt_e = FWD_W;

    hz.fwd_rt_m = (m_q.rt != '0 && w_q.we && m_q.rt == w_q.dst) ? FWD_W : FWD_RF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      if (hz.stall) begin
        e_q <= '0;
      end else begin
        e_q.rs   <= hz.rs_d;
        e_q.rt   <= hz.rt_d;
        e_q.dst  <= keep_dst(hz.reg_write_d, hz.dst_d);
        e_q.we   <= hz.reg_write_d && (hz.dst_d != '0);
        e_q.tnew <= sat_dec(hz.t_new_d);
      end
      m_q.rt   <= e_q.rt;
      m_q.dst  <= e_q.dst;
      m_q.we   <= e_q.we;
      m_q.tnew <= sat_dec(e_q.tnew);
      w_q.dst  <= m_q.dst;
      w_q.we   <= m_q.we;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed hazard scenarios with hand-computed stall/forward expectations.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  hazard_unit_if hz ();

  hazard_unit dut (.clk(clk), .reset_n(reset_n), .hz(hz));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic drive(input int rs, input int rt, input int tu_rs, input int tu_rt,
                       input int tn, input int we, input int dst);
    hz.rs_d        = reg_t'(rs);
    hz.rt_d        = reg_t'(rt);
    hz.t_use_rs_d  = tw_t'(tu_rs);
    hz.t_use_rt_d  = tw_t'(tu_rt);
    hz.t_new_d     = tw_t'(tn);
    hz.reg_write_d = (we != 0);
    hz.dst_d       = reg_t'(dst);
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 3, 3, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    drive(4, 4, 0, 0, 3, 1, 4);
    chk("reset_stall", hz.stall, 0);
    chk("reset_fwd_rs_d", hz.fwd_rs_d, 0);
    chk("reset_fwd_rt_m", hz.fwd_rt_m, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    flush();

    // lw $1 ; addu $2,$1,$1
    drive(0, 1, 1, 3, 3, 1, 1);
    chk("t1_lw_stall", hz.stall, 0);
    tick();
    drive(1, 1, 1, 1, 2, 1, 2);
    chk("t1_stall_a", hz.stall, 1);
    tick();
    chk("t1_stall_b", hz.stall, 0);
    tick();
    nop();
    chk("t1_fwd_rs_e", hz.fwd_rs_e, 3);
    chk("t1_fwd_rt_e", hz.fwd_rt_e, 3);
    flush();

    // addu $3 ; beq $3,$0
    drive(1, 2, 1, 1, 2, 1, 3);
    tick();
    drive(3, 0, 0, 0, 0, 0, 0);
    chk("t2_stall_a", hz.stall, 1);
    tick();
    chk("t2_stall_b", hz.stall, 0);
    chk("t2_fwd_rs_d", hz.fwd_rs_d, 2);
    flush();

    // lw $4 ; beq $4,$4
    drive(0, 4, 1, 3, 3, 1, 4);
    tick();
    drive(4, 4, 0, 0, 0, 0, 0);
    chk("t3_stall_a", hz.stall, 1);
    tick();
    chk("t3_stall_b", hz.stall, 1);
    tick();
    chk("t3_stall_c", hz.stall, 0);
    chk("t3_fwd_rs_d", hz.fwd_rs_d, 3);
    chk("t3_fwd_rt_d", hz.fwd_rt_d, 3);
    flush();

    // jal ; jr $31
    drive(0, 0, 3, 3, 1, 1, 31);
    tick();
    drive(31, 0, 0, 3, 0, 0, 0);
    chk("t4_stall", hz.stall, 0);
    chk("t4_fwd_rs_d", hz.fwd_rs_d, 1);
    flush();

    // ori $0 ; addu $5,$0,$0
    drive(0, 0, 1, 3, 2, 1, 0);
    tick();
    drive(0, 0, 1, 1, 2, 1, 5);
    chk("t5_stall", hz.stall, 0);
    chk("t5_fwd_rs_d", hz.fwd_rs_d, 0);
    chk("t5_fwd_rt_d", hz.fwd_rt_d, 0);
    tick();
    nop();
    chk("t5_fwd_rs_e", hz.fwd_rs_e, 0);
    chk("t5_fwd_rt_e", hz.fwd_rt_e, 0);
    flush();

    // lw $6 ; sw $6,0($0)
    drive(0, 6, 1, 3, 3, 1, 6);
    tick();
    drive(0, 6, 1, 2, 0, 0, 0);
    chk("t5s_stall", hz.stall, 0);
    tick();
    nop();
    chk("t5s_fwd_rt_e", hz.fwd_rt_e, 0);
    tick();
    chk("t5s_fwd_rt_m", hz.fwd_rt_m, 3);
    flush();

    // async reset in the middle of the lw/beq stall
    drive(0, 4, 1, 3, 3, 1, 4);
    tick();
    drive(4, 4, 0, 0, 0, 0, 0);
    chk("t6_stall_pre", hz.stall, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_stall_rst", hz.stall, 0);
    chk("t6_fwd_rs_d", hz.fwd_rs_d, 0);
    chk("t6_fwd_rt_d", hz.fwd_rt_d, 0);
    chk("t6_fwd_rs_e", hz.fwd_rs_e, 0);
    chk("t6_fwd_rt_m", hz.fwd_rt_m, 0);
    tick();
    reset_n = 1'b1;
    drive(8, 9, 1, 1, 2, 1, 7);
    chk("t6_addu_stall", hz.stall, 0);
    tick();
    nop();
    chk("t6_addu_fwd_rs_e", hz.fwd_rs_e, 0);
    chk("t6_addu_fwd_rt_e", hz.fwd_rt_e, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
